// File: rtl/aes_tiled_arb_if.sv
// rtl/aes_tiled_arb_if.sv - request, response and shared-datapath bundle for the AES tile arbiter
interface aes_tiled_arb_if;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][1:0]   req_op;
    logic [1:0]        req_dec;
    logic [1:0]        req_hi;
    logic [1:0][31:0]  req_rs1;
    logic [1:0][31:0]  req_rs2;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [1:0][31:0]  rsp_rd;
    logic [1:0]        rsp_err;
    logic              dp_valid;
    logic              dp_dec;
    logic              dp_op_sb;
    logic              dp_op_sbsr;
    logic              dp_op_mix;
    logic              dp_hi;
    logic [31:0]       dp_rs1;
    logic [31:0]       dp_rs2;
    logic              dp_ready;
    logic [31:0]       dp_rd;

    modport slave (
        input  req_valid, req_op, req_dec, req_hi, req_rs1, req_rs2,
        input  rsp_ready, dp_ready, dp_rd,
        output req_ready, rsp_valid, rsp_rd, rsp_err,
        output dp_valid, dp_dec, dp_op_sb, dp_op_sbsr, dp_op_mix, dp_hi, dp_rs1, dp_rs2
    );

    modport master (
        output req_valid, req_op, req_dec, req_hi, req_rs1, req_rs2,
        output rsp_ready, dp_ready, dp_rd,
        input  req_ready, rsp_valid, rsp_rd, rsp_err,
        input  dp_valid, dp_dec, dp_op_sb, dp_op_sbsr, dp_op_mix, dp_hi, dp_rs1, dp_rs2
    );
endinterface

// File: rtl/aes_tiled_arb.sv
// rtl/aes_tiled_arb.sv - two-requester round-robin arbiter in front of a shared single-cycle AES datapath
module aes_tiled_arb #(
    parameter int unsigned DECRYPT_EN = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    g_clk,
    input  logic                    g_resetn,
    aes_tiled_arb_if.slave          bus,
    output logic [1:0][CNT_W-1:0]   grant_cnt
);
    localparam bit DEC_OK = (DECRYPT_EN != 0);

    logic       last_gnt;
    logic [1:0] elig;
    logic [1:0] grant;
    logic       any_gnt;
    logic       sel;
    logic [1:0] op_s;
    logic       dec_s;
    logic       illegal;
    logic       legal_go;
    logic       fire;

    // A requester may only go if its response slot is empty or is being drained now.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            elig[i] = g_resetn && bus.req_valid[i] && (!bus.rsp_valid[i] || bus.rsp_ready[i]);
        end
        grant[0] = elig[0] && (!elig[1] || last_gnt);
        grant[1] = elig[1] && (!elig[0] || !last_gnt);
        any_gnt  = |grant;
        sel      = grant[1];
        op_s     = bus.req_op[sel];
        dec_s    = bus.req_dec[sel];
        illegal  = (op_s == 2'b11) || (dec_s && !DEC_OK);
        legal_go = any_gnt && !illegal;
        fire     = any_gnt && bus.dp_ready;
    end

    // Illegal requests still occupy the datapath slot but with every operation select cleared.
    assign bus.dp_valid   = any_gnt;
    assign bus.dp_dec     = legal_go && dec_s;
    assign bus.dp_op_sb   = legal_go && (op_s == 2'b00);
    assign bus.dp_op_sbsr = legal_go && (op_s == 2'b01);
    assign bus.dp_op_mix  = legal_go && (op_s == 2'b10);
    assign bus.dp_hi      = any_gnt && bus.req_hi[sel];
    assign bus.dp_rs1     = any_gnt ? bus.req_rs1[sel] : 32'd0;
    assign bus.dp_rs2     = any_gnt ? bus.req_rs2[sel] : 32'd0;
    assign bus.req_ready  = grant & {2{bus.dp_ready}};

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            bus.rsp_valid <= '0;
            bus.rsp_rd    <= '0;
            bus.rsp_err   <= '0;
            last_gnt      <= 1'b1;
            grant_cnt     <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (fire && (sel == 1'(i))) begin
                    bus.rsp_valid[i] <= 1'b1;
                    bus.rsp_rd[i]    <= illegal ? 32'd0 : bus.dp_rd;
                    bus.rsp_err[i]   <= illegal;
                end else if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
                    bus.rsp_valid[i] <= 1'b0;
                end
            end
            if (fire) begin
                last_gnt <= sel;
                if (grant_cnt[sel] != {CNT_W{1'b1}}) begin
                    grant_cnt[sel] <= grant_cnt[sel] + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_tiled_arb.sv
// tb/tb_aes_tiled_arb.sv - bench for aes_tiled_arb: two parameterisations against a behavioural model
module tb_aes_tiled_arb;
    logic g_clk;
    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    logic              r_resetn;
    logic [1:0]        r_valid, r_dec, r_hi, r_rsp_ready;
    logic [1:0][1:0]   r_op;
    logic [1:0][31:0]  r_rs1, r_rs2;
    logic              r_dp_ready;
    logic [31:0]       r_dp_rd;

    aes_tiled_arb_if ifa();
    aes_tiled_arb_if ifb();
    logic [1:0][15:0] cnt_a;
    logic [1:0][3:0]  cnt_b;

    assign ifa.req_valid = r_valid;     assign ifb.req_valid = r_valid;
    assign ifa.req_op    = r_op;        assign ifb.req_op    = r_op;
    assign ifa.req_dec   = r_dec;       assign ifb.req_dec   = r_dec;
    assign ifa.req_hi    = r_hi;        assign ifb.req_hi    = r_hi;
    assign ifa.req_rs1   = r_rs1;       assign ifb.req_rs1   = r_rs1;
    assign ifa.req_rs2   = r_rs2;       assign ifb.req_rs2   = r_rs2;
    assign ifa.rsp_ready = r_rsp_ready; assign ifb.rsp_ready = r_rsp_ready;
    assign ifa.dp_ready  = r_dp_ready;  assign ifb.dp_ready  = r_dp_ready;
    assign ifa.dp_rd     = r_dp_rd;     assign ifb.dp_rd     = r_dp_rd;

    aes_tiled_arb #(.DECRYPT_EN(1), .CNT_W(16)) dut_a (
        .g_clk(g_clk), .g_resetn(r_resetn), .bus(ifa), .grant_cnt(cnt_a));
    aes_tiled_arb #(.DECRYPT_EN(0), .CNT_W(4)) dut_b (
        .g_clk(g_clk), .g_resetn(r_resetn), .bus(ifb), .grant_cnt(cnt_b));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Output views indexed by instance: 0 = decrypt enabled / 16-bit, 1 = decrypt disabled / 4-bit.
    logic [1:0]  o_rr[2], o_rv[2], o_err[2];
    logic [5:0]  o_ctl[2];
    logic [31:0] o_rs1[2], o_rs2[2];
    logic [31:0] o_rd[2][2];
    logic [15:0] o_cnt[2][2];

    assign o_rr[0] = ifa.req_ready;  assign o_rr[1] = ifb.req_ready;
    assign o_rv[0] = ifa.rsp_valid;  assign o_rv[1] = ifb.rsp_valid;
    assign o_err[0] = ifa.rsp_err;   assign o_err[1] = ifb.rsp_err;
    assign o_ctl[0] = {ifa.dp_valid, ifa.dp_dec, ifa.dp_op_sb, ifa.dp_op_sbsr, ifa.dp_op_mix, ifa.dp_hi};
    assign o_ctl[1] = {ifb.dp_valid, ifb.dp_dec, ifb.dp_op_sb, ifb.dp_op_sbsr, ifb.dp_op_mix, ifb.dp_hi};
    assign o_rs1[0] = ifa.dp_rs1;    assign o_rs1[1] = ifb.dp_rs1;
    assign o_rs2[0] = ifa.dp_rs2;    assign o_rs2[1] = ifb.dp_rs2;
    assign o_rd[0][0] = ifa.rsp_rd[0]; assign o_rd[0][1] = ifa.rsp_rd[1];
    assign o_rd[1][0] = ifb.rsp_rd[0]; assign o_rd[1][1] = ifb.rsp_rd[1];
    assign o_cnt[0][0] = cnt_a[0];   assign o_cnt[0][1] = cnt_a[1];
    assign o_cnt[1][0] = {12'd0, cnt_b[0]};
    assign o_cnt[1][1] = {12'd0, cnt_b[1]};

    // Model state: what each response slot, counter and the round-robin owner hold after the coming edge.
    bit          mon_en;
    bit          m_rv[2][2];
    bit          m_err[2][2];
    logic [31:0] m_rd[2][2];
    bit          m_last[2];
    int          m_cnt[2][2];
    int          cmax[2];
    bit          dec_en[2];

    initial begin
        mon_en = 0;
        cmax[0] = 65535; cmax[1] = 15;
        dec_en[0] = 1;   dec_en[1] = 0;
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1;
            for (int i = 0; i < 2; i++) begin
                m_rv[k][i] = 0; m_err[k][i] = 0; m_rd[k][i] = 0; m_cnt[k][i] = 0;
            end
        end
    end

    always @(negedge g_clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                int         g;
                bit         bad, done;
                bit         el[2];
                logic [5:0] ectl;
                logic [1:0] err_rr;
                for (int i = 0; i < 2; i++)
                    el[i] = r_resetn && r_valid[i] && (!m_rv[k][i] || r_rsp_ready[i]);
                if (el[0] && el[1]) g = 1 - int'(m_last[k]);
                else if (el[0])     g = 0;
                else if (el[1])     g = 1;
                else                g = -1;
                bad    = 0;
                ectl   = 6'd0;
                err_rr = 2'b00;
                if (g >= 0) begin
                    bad = (r_op[g] == 2'd3) || (r_dec[g] && !dec_en[k]);
                    ectl[5] = 1;
                    ectl[4] = !bad && r_dec[g];
                    ectl[3] = !bad && (r_op[g] == 2'd0);
                    ectl[2] = !bad && (r_op[g] == 2'd1);
                    ectl[1] = !bad && (r_op[g] == 2'd2);
                    ectl[0] = r_hi[g];
                    if (r_dp_ready) err_rr[g] = 1'b1;
                end
                chk($sformatf("req_ready[%0d]", k), o_rr[k], err_rr);
                chk($sformatf("dp_ctl[%0d]", k), o_ctl[k], ectl);
                if (g >= 0) begin
                    chk($sformatf("dp_rs1[%0d]", k), o_rs1[k], r_rs1[g]);
                    chk($sformatf("dp_rs2[%0d]", k), o_rs2[k], r_rs2[g]);
                end
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("rsp_valid[%0d][%0d]", k, i), o_rv[k][i], m_rv[k][i]);
                    if (m_rv[k][i]) begin
                        chk($sformatf("rsp_rd[%0d][%0d]", k, i), o_rd[k][i], m_rd[k][i]);
                        chk($sformatf("rsp_err[%0d][%0d]", k, i), o_err[k][i], m_err[k][i]);
                    end
                    chk($sformatf("grant_cnt[%0d][%0d]", k, i), o_cnt[k][i], m_cnt[k][i]);
                end
                done = (g >= 0) && r_dp_ready;
                if (!r_resetn) begin
                    m_last[k] = 1;
                    for (int i = 0; i < 2; i++) begin
                        m_rv[k][i] = 0; m_err[k][i] = 0; m_rd[k][i] = 0; m_cnt[k][i] = 0;
                    end
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        if (done && g == i) begin
                            m_rv[k][i]  = 1;
                            m_err[k][i] = bad;
                            m_rd[k][i]  = bad ? 32'd0 : r_dp_rd;
                        end else if (m_rv[k][i] && r_rsp_ready[i]) begin
                            m_rv[k][i] = 0;
                        end
                    end
                    if (done) begin
                        m_last[k] = (g == 1);
                        if (m_cnt[k][g] < cmax[k]) m_cnt[k][g] = m_cnt[k][g] + 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic rand_fields(input bit legal);
        for (int i = 0; i < 2; i++) begin
            r_op[i]  = legal ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
            r_dec[i] = legal ? 1'b0 : 1'($urandom_range(0, 1));
            r_hi[i]  = 1'($urandom_range(0, 1));
            r_rs1[i] = $urandom;
            r_rs2[i] = $urandom;
        end
        r_dp_rd = $urandom;
    endtask

    logic [3:0]  seq;
    logic [31:0] v;

    initial begin
        r_resetn = 0; r_valid = 0; r_dec = 0; r_hi = 0; r_rsp_ready = 0;
        r_op = '0; r_rs1 = '0; r_rs2 = '0; r_dp_ready = 1; r_dp_rd = 0;
        repeat (2) tick();
        mon_en = 1;
        @(negedge g_clk);
        chk("reset rsp_valid", ifa.rsp_valid, 2'b00);
        chk("reset grant_cnt", cnt_a, 32'd0);
        chk("reset dp_valid", ifa.dp_valid, 1'b0);
        tick();

        // Single sbsr request.
        r_resetn = 1; r_rsp_ready = 2'b11; r_dp_ready = 1; r_dp_rd = 32'hCAFEF00D;
        r_valid = 2'b01; r_op[0] = 2'b01; r_hi[0] = 0;
        r_rs1[0] = 32'h00112233; r_rs2[0] = 32'h44556677;
        @(negedge g_clk);
        chk("single sbsr", ifa.dp_op_sbsr, 1'b1);
        chk("single rs1", ifa.dp_rs1, 32'h00112233);
        chk("single rs2", ifa.dp_rs2, 32'h44556677);
        chk("single req_ready", ifa.req_ready, 2'b01);
        tick();
        r_valid = 2'b00;
        @(negedge g_clk);
        chk("single rsp_valid", ifa.rsp_valid[0], 1'b1);
        chk("single rsp_rd", ifa.rsp_rd[0], 32'hCAFEF00D);
        tick();

        // Contention from a fresh reset alternates starting with requester 0.
        r_resetn = 0; tick(); r_resetn = 1;
        r_valid = 2'b11; rand_fields(1);
        for (int c = 0; c < 4; c++) begin
            @(negedge g_clk);
            seq[c] = ifa.req_ready[1];
            tick();
            rand_fields(1);
        end
        r_valid = 2'b00;
        @(negedge g_clk);
        chk("contention order", seq, 4'b1010);
        chk("contention cnt", cnt_a, {16'd2, 16'd2});
        tick();

        // Backpressure on a full response slot.
        r_resetn = 0; tick(); r_resetn = 1;
        r_rsp_ready = 2'b00; r_valid = 2'b01; r_op[0] = 2'b00;
        tick();
        @(negedge g_clk);
        chk("bp req_ready", ifa.req_ready, 2'b00);
        chk("bp dp_valid", ifa.dp_valid, 1'b0);
        tick();
        r_rsp_ready = 2'b01; r_dp_rd = 32'hA5A50F0F;
        @(negedge g_clk);
        chk("bp release ready", ifa.req_ready, 2'b01);
        tick();
        r_valid = 2'b00;
        @(negedge g_clk);
        chk("bp reload valid", ifa.rsp_valid[0], 1'b1);
        chk("bp reload rd", ifa.rsp_rd[0], 32'hA5A50F0F);
        tick();

        // Illegal op, disabled decrypt, and a datapath stall.
        r_resetn = 0; tick(); r_resetn = 1;
        r_rsp_ready = 2'b11; r_dp_ready = 1; r_dp_rd = 32'h12345678;
        r_valid = 2'b10; r_op[1] = 2'b11; r_dec = 2'b00;
        @(negedge g_clk);
        chk("illegal dp_valid", ifa.dp_valid, 1'b1);
        chk("illegal ops", {ifa.dp_op_sb, ifa.dp_op_sbsr, ifa.dp_op_mix}, 3'b000);
        tick();
        r_valid = 2'b01; r_op[0] = 2'b10; r_dec = 2'b01;
        @(negedge g_clk);
        chk("illegal err", ifa.rsp_err[1], 1'b1);
        chk("illegal rd", ifa.rsp_rd[1], 32'd0);
        chk("dec en dp_dec", ifa.dp_dec, 1'b1);
        chk("dec dis dp_dec", ifb.dp_dec, 1'b0);
        chk("dec dis mix", ifb.dp_op_mix, 1'b0);
        tick();
        r_valid = 2'b11; r_op[0] = 2'b00; r_op[1] = 2'b01; r_dec = 2'b00; r_dp_ready = 0;
        @(negedge g_clk);
        chk("dec dis err", ifb.rsp_err[0], 1'b1);
        chk("dec en err", ifa.rsp_err[0], 1'b0);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge g_clk);
            chk("stall req_ready", ifa.req_ready, 2'b00);
            tick();
        end
        r_dp_ready = 1;
        @(negedge g_clk);
        chk("stall resume grant", ifa.req_ready, 2'b10);
        tick();

        // Reset in the middle of a stream.
        for (int c = 0; c < 5; c++) begin
            rand_fields(1);
            tick();
        end
        r_resetn = 0;
        @(negedge g_clk);
        chk("in-reset req_ready", ifa.req_ready, 2'b00);
        chk("in-reset dp_valid", ifa.dp_valid, 1'b0);
        tick();
        r_resetn = 1;
        @(negedge g_clk);
        chk("post-reset rsp_valid", ifa.rsp_valid, 2'b00);
        chk("post-reset cnt", cnt_a, 32'd0);
        chk("post-reset winner", ifa.req_ready, 2'b01);
        tick();

        // Counter saturation.
        r_resetn = 0; tick(); r_resetn = 1;
        r_valid = 2'b01;
        repeat (20) begin
            rand_fields(1);
            tick();
        end
        r_valid = 2'b00;
        @(negedge g_clk);
        chk("sat cnt 4-bit", cnt_b[0], 4'd15);
        chk("sat cnt 16-bit", cnt_a[0], 16'd20);
        tick();

        // Random traffic, including illegal requests and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rand_fields(0);
            r_valid     = 2'($urandom_range(0, 3));
            r_rsp_ready = 2'($urandom_range(0, 3));
            r_dp_ready  = ($urandom_range(0, 4) != 0);
            r_resetn    = ($urandom_range(0, 99) != 0);
            tick();
        end
        r_valid = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_tiled_arb.md
AES_TILED_ARB -- requirements
Module: aes_tiled_arb

Interface
REQ-001 Parameter DECRYPT_EN, default 1, enables decrypt requests; when 0, any request with dec=1 completes as an error.
REQ-002 Parameter CNT_W, default 16, sets the width of the per-requester grant counters.
REQ-003 g_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 g_resetn  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  2  per requester i (bit i): request present.
REQ-006 req_ready  output  2  per requester: request accepted this cycle.
REQ-007 req_op  input  2x2  per requester: 00 sb, 01 sbsr, 10 mix, 11 illegal.
REQ-008 req_dec, req_hi  input  2 each  per requester: decrypt select, high/low half select.
REQ-009 req_rs1, req_rs2  input  2x32 each  per requester: source operands.
REQ-010 rsp_valid  output  2  per requester: response buffer holds a result.
REQ-011 rsp_ready  input  2  per requester: consumer takes the response.
REQ-012 rsp_rd, rsp_err  output  2x32 / 2  per requester: result word, error flag.
REQ-013 dp_valid, dp_dec, dp_op_sb, dp_op_sbsr, dp_op_mix, dp_hi  output  1 each  shared AES datapath controls.
REQ-014 dp_rs1, dp_rs2  output  32 each  shared datapath operands.
REQ-015 dp_ready  input  1; dp_rd  input  32  shared datapath completion and result, combinational in the same cycle.
REQ-016 grant_cnt  output  2xCNT_W  per-requester accepted-request counters.

Function
REQ-017 Requester i is eligible when req_valid[i]=1 and its response buffer is free or draining: !rsp_valid[i] || rsp_ready[i].
REQ-018 One eligible requester: it is granted.
REQ-019 Both eligible: the requester not granted most recently wins, using register last_gnt.
REQ-020 last_gnt resets to 1, so requester 0 wins the first contention.
REQ-021 No requester eligible: dp_valid=0, all dp_* controls are 0, and last_gnt holds.
REQ-022 Grant is combinational: dp_* mirrors the granted requester's fields, with dp_valid=1.
REQ-023 Op decode: op 00 → dp_op_sb=1; op 01 → dp_op_sbsr=1; op 10 → dp_op_mix=1; at most one of the three is set.
REQ-024 dp_dec = req_dec && DECRYPT_EN.
REQ-025 req_ready[g] = grant[g] && dp_ready; the request completes only when dp_valid && dp_ready.
REQ-026 If dp_ready=0: no acceptance, no state change, last_gnt unchanged; the requester stays eligible next cycle.
REQ-027 On completion of a legal request: rsp_rd[g] <= dp_rd, rsp_err[g] <= 0, rsp_valid[g] <= 1 at the next edge (latency 1 cycle).
REQ-028 Illegal request (op=11, or dec=1 with DECRYPT_EN=0): dp_valid=1 is still issued but all dp_op_* are 0 and dp_dec=0.
REQ-029 An illegal request still requires dp_ready to complete; it completes with rsp_rd[g] <= 0 and rsp_err[g] <= 1.
REQ-030 Response drain: rsp_valid[i] && rsp_ready[i] with no new completion for i → rsp_valid[i] <= 0 next cycle.
REQ-031 Drain plus new completion for i in the same cycle: the buffer reloads and rsp_valid[i] stays 1 (back-to-back throughput of 1 per cycle per requester).
REQ-032 rsp_rd and rsp_err hold stable while rsp_valid=1 && rsp_ready=0.
REQ-033 At most one completion per cycle across both requesters.
REQ-034 On each completion, last_gnt <= g and grant_cnt[g] increments.
REQ-035 grant_cnt saturates at all-ones and does not wrap.
REQ-036 Outputs depend on req_* only through the grant mux; no combinational path exists from rsp_ready to rsp_valid.

Reset
REQ-037 When g_resetn=0 at a clock edge: rsp_valid=0, rsp_rd=0, rsp_err=0, last_gnt=1, grant_cnt=0.
REQ-038 While g_resetn=0, req_ready=0 and dp_valid=0 regardless of inputs; any request active in that cycle is discarded with no response.
REQ-039 Operation resumes on the first edge after g_resetn returns to 1.

Verification
REQ-040 Single request, dp_ready=1: req0 op=01, hi=0, rs1=0x00112233, rs2=0x44556677 → dp_op_sbsr=1 and dp_rs1/dp_rs2 match same cycle; rsp_valid[0]=1 next cycle with rsp_rd = dp_rd sampled at acceptance.
REQ-041 Contention: both requesters valid for 4 cycles, rsp_ready=11 → grants in order 0,1,0,1; grant_cnt = {2,2}.
REQ-042 Backpressure: rsp_valid[0]=1, rsp_ready[0]=0, req0 valid, req1 idle → req_ready=00, dp_valid=0; raising rsp_ready[0] grants req0 in that same cycle and rsp_valid[0] stays 1.
REQ-043 Errors and stall: req1 op=11 → rsp_err[1]=1, rsp_rd[1]=0; with DECRYPT_EN=0, req0 dec=1 op=10 → rsp_err[0]=1; dp_ready=0 for 3 cycles → no completion and last_gnt unchanged.
REQ-044 Reset mid-stream: both requesters streaming, g_resetn=0 for 1 cycle → all rsp_valid=0, grant_cnt=0, and requester 0 wins the next contention.
REQ-045 Saturation: CNT_W=4, 20 accepted requests on req0 → grant_cnt[0]=15.
